// File: rtl/uart_receiver_cfg.sv
// uart_receiver_cfg
//   Parametrised UART receiver with 5..9 data bits, optional odd/even parity
//   and 1 or 2 stop bits. The asynchronous rx line is oversampled with a
//   divided tick, and every bit is a 3-sample majority vote taken around the
//   bit midpoint. Each received word is held with a valid/ready handshake,
//   together with parity, framing and overrun flags.
//
// Ports
//   clk          in   single clock
//   reset        in   asynchronous, active-high
//   rx           in   serial line, idles high, LSB first
//   data         out  received word (DATA_BITS wide)
//   data_valid   out  word and flags available
//   data_ready   in   consumer accepts the held word
//   parity_err   out  parity mismatch on the held word
//   framing_err  out  a stop bit of the held word was sampled low
//   overrun_err  out  frames were lost while a word was held
//   receiving    out  frame in progress (start detect .. completion/abort)
//   baud_tick    out  single-cycle oversample tick (debug)
module uart_receiver_cfg #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 receiving,
  output logic                 baud_tick
);

  localparam int unsigned BAUD_OS = BAUD * OVERSAMPLE;
  localparam int unsigned DIV     = (CLK_FREQ + BAUD_OS / 2) / BAUD_OS;
  localparam int unsigned TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OSW     = $clog2(OVERSAMPLE);
  localparam int unsigned BCW     = $clog2(DATA_BITS + 1);

  // Tick indices are 0-based, so the three samples land on the
  // (OVERSAMPLE/2-1)th, (OVERSAMPLE/2)th and (OVERSAMPLE/2+1)th tick of a bit.
  localparam logic [OSW-1:0] SAMP0   = OSW'(OVERSAMPLE / 2 - 2);
  localparam logic [OSW-1:0] SAMP1   = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] DECIDE  = OSW'(OVERSAMPLE / 2);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0]  TICK_LAST = TW'(DIV - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q;
  logic                 rx_meta_q;
  logic                 rxs_q;
  logic                 rxs_prev_q;
  logic                 armed_q;
  logic [TW-1:0]        tick_cnt_q;
  logic [OSW-1:0]       os_cnt_q;
  logic [BCW-1:0]       bit_cnt_q;
  logic [1:0]           samp_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 fe_acc_q;

  logic tick;
  logic start_det;
  logic decide;
  logic bit_val;
  logic complete;
  logic perr_new;
  logic ferr_new;

  // Two-flop synchronizer plus edge-detect history, all idling high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  assign tick      = (tick_cnt_q == TICK_LAST);
  assign baud_tick = tick;
  assign start_det = (state_q == S_IDLE) && armed_q && rxs_prev_q && !rxs_q;
  assign decide    = tick && (os_cnt_q == DECIDE);

  // Third sample is the live synchronized value at the decision tick.
  assign bit_val = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxs_q) | (samp_q[0] & rxs_q);

  assign complete = decide && (state_q == S_STOP) && (bit_cnt_q == STOP_LAST);
  assign ferr_new = fe_acc_q | ~bit_val;

  always_comb begin
    perr_new = 1'b0;
    if (PARITY == 1) begin
      perr_new = ~(^shift_q ^ par_q);
    end else if (PARITY == 2) begin
      perr_new = ^shift_q ^ par_q;
    end
  end

  // Tick divider; restarted on start detect so ticks are phase-aligned to the frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else if (start_det || tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      armed_q     <= 1'b1;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      samp_q      <= '1;
      shift_q     <= '0;
      par_q       <= 1'b0;
      fe_acc_q    <= 1'b0;
      receiving   <= 1'b0;
      data        <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (tick && (state_q != S_IDLE)) begin
        os_cnt_q <= (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OSW'(1);
        if ((os_cnt_q == SAMP0) || (os_cnt_q == SAMP1)) begin
          samp_q <= {samp_q[0], rxs_q};
        end
      end

      unique case (state_q)
        S_IDLE: begin
          if (rxs_q) begin
            armed_q <= 1'b1;
          end
          if (start_det) begin
            state_q   <= S_START;
            os_cnt_q  <= '0;
            fe_acc_q  <= 1'b0;
            receiving <= 1'b1;
          end
        end
        S_START: begin
          if (decide) begin
            if (!bit_val) begin
              state_q   <= S_DATA;
              bit_cnt_q <= '0;
            end else begin
              state_q   <= S_IDLE;
              receiving <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (decide) begin
            shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == DATA_LAST) begin
              state_q   <= (PARITY != 0) ? S_PARITY : S_STOP;
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + BCW'(1);
            end
          end
        end
        S_PARITY: begin
          if (decide) begin
            par_q   <= bit_val;
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (decide) begin
            if (!bit_val) begin
              fe_acc_q <= 1'b1;
            end
            if (bit_cnt_q == STOP_LAST) begin
              // Leave at the last stop midpoint so a back-to-back start edge
              // is caught; re-arming waits for rx to be seen high again.
              state_q   <= S_IDLE;
              armed_q   <= 1'b0;
              receiving <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q + BCW'(1);
            end
          end
        end
        default: begin
          state_q   <= S_IDLE;
          receiving <= 1'b0;
        end
      endcase

      // A completing frame takes priority over a plain handshake clear.
      if (complete) begin
        if (!data_valid || data_ready) begin
          data        <= shift_q;
          parity_err  <= perr_new;
          framing_err <= ferr_new;
          overrun_err <= 1'b0;
          data_valid  <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid  <= 1'b0;
        parity_err  <= 1'b0;
        framing_err <= 1'b0;
        overrun_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver_cfg.sv
module tb_uart_receiver_cfg;

  localparam int DEF_BIT  = 864;
  localparam int FAST_BIT = 64;

  logic clk = 1'b0;
  logic reset;
  logic rx;
  logic data_ready;

  always #5 clk = ~clk;

  // Four receivers share the line; only the one a check targets is examined.
  // 0: defaults (8N1, 864 clk/bit)  1: fast 8N1  2: fast 8E1  3: fast 7N2
  logic [7:0] d_def, d_fast, d_par;
  logic [6:0] d_7s2;
  logic [3:0] dv_v, pe_v, fe_v, ov_v, rcv_v, tk_v;
  logic [8:0] data_v [4];

  assign data_v[0] = {1'b0, d_def};
  assign data_v[1] = {1'b0, d_fast};
  assign data_v[2] = {1'b0, d_par};
  assign data_v[3] = {2'b00, d_7s2};

  uart_receiver_cfg u_def (
    .clk(clk), .reset(reset), .rx(rx), .data(d_def), .data_valid(dv_v[0]),
    .data_ready(data_ready), .parity_err(pe_v[0]), .framing_err(fe_v[0]),
    .overrun_err(ov_v[0]), .receiving(rcv_v[0]), .baud_tick(tk_v[0])
  );

  uart_receiver_cfg #(.CLK_FREQ(100_000_000), .BAUD(1_562_500)) u_fast (
    .clk(clk), .reset(reset), .rx(rx), .data(d_fast), .data_valid(dv_v[1]),
    .data_ready(data_ready), .parity_err(pe_v[1]), .framing_err(fe_v[1]),
    .overrun_err(ov_v[1]), .receiving(rcv_v[1]), .baud_tick(tk_v[1])
  );

  uart_receiver_cfg #(.CLK_FREQ(100_000_000), .BAUD(1_562_500), .PARITY(2)) u_par (
    .clk(clk), .reset(reset), .rx(rx), .data(d_par), .data_valid(dv_v[2]),
    .data_ready(data_ready), .parity_err(pe_v[2]), .framing_err(fe_v[2]),
    .overrun_err(ov_v[2]), .receiving(rcv_v[2]), .baud_tick(tk_v[2])
  );

  uart_receiver_cfg #(.CLK_FREQ(100_000_000), .BAUD(1_562_500), .DATA_BITS(7),
                      .STOP_BITS(2)) u_7s2 (
    .clk(clk), .reset(reset), .rx(rx), .data(d_7s2), .data_valid(dv_v[3]),
    .data_ready(data_ready), .parity_err(pe_v[3]), .framing_err(fe_v[3]),
    .overrun_err(ov_v[3]), .receiving(rcv_v[3]), .baud_tick(tk_v[3])
  );

  int checks = 0;
  int failures = 0;

  // Word capture on each rising edge of data_valid.
  int         nval [4] = '{default: 0};
  logic [8:0] ldat [4];
  logic       lpe  [4];
  logic       lfe  [4];
  logic [3:0] dvp = '0;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (dv_v[i] && !dvp[i]) begin
        nval[i]++;
        ldat[i] = data_v[i];
        lpe[i]  = pe_v[i];
        lfe[i]  = fe_v[i];
      end
    end
    dvp = dv_v;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int clks);
    @(posedge clk);
    #1 rx = b;
    repeat (clks - 1) @(posedge clk);
  endtask

  task automatic idle(input int clks);
    repeat (clks) @(posedge clk);
  endtask

  task automatic send_frame(input logic [8:0] w, input int nb, input int par_en,
                            input logic pb, input int ns, input logic [1:0] sv,
                            input int bc);
    drive_bit(1'b0, bc);
    for (int i = 0; i < nb; i++) drive_bit(w[i], bc);
    if (par_en != 0) drive_bit(pb, bc);
    for (int i = 0; i < ns; i++) drive_bit(sv[i], bc);
    drive_bit(1'b1, bc);
  endtask

  task automatic chk_reset_outputs(input int s, input string tag);
    chk($sformatf("%s_data", tag), data_v[s], 0);
    chk($sformatf("%s_valid", tag), dv_v[s], 0);
    chk($sformatf("%s_perr", tag), pe_v[s], 0);
    chk($sformatf("%s_ferr", tag), fe_v[s], 0);
    chk($sformatf("%s_ovr", tag), ov_v[s], 0);
    chk($sformatf("%s_rcv", tag), rcv_v[s], 0);
    chk($sformatf("%s_tick", tag), tk_v[s], 0);
  endtask

  task automatic chk_word(input int s, input int n0, input logic [8:0] ed,
                          input logic ep, input logic ef, input string tag);
    chk($sformatf("%s_count", tag), nval[s] - n0, 1);
    chk($sformatf("%s_data", tag), ldat[s], ed);
    chk($sformatf("%s_perr", tag), lpe[s], ep);
    chk($sformatf("%s_ferr", tag), lfe[s], ef);
  endtask

  typedef struct {
    int         sel;
    logic [8:0] word;
    int         nb;
    int         par_en;
    logic       pb;
    int         ns;
    logic [1:0] sv;
    logic [8:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl [NV];

  initial begin
    int s;
    int n0;

    tbl[0]  = '{1, 9'h000, 8, 0, 1'b0, 1, 2'b11, 9'h000, 1'b0, 1'b0};
    tbl[1]  = '{1, 9'h0FF, 8, 0, 1'b0, 1, 2'b11, 9'h0FF, 1'b0, 1'b0};
    tbl[2]  = '{1, 9'h0A5, 8, 0, 1'b0, 1, 2'b10, 9'h0A5, 1'b0, 1'b1};
    tbl[3]  = '{1, 9'h080, 8, 0, 1'b0, 1, 2'b11, 9'h080, 1'b0, 1'b0};
    tbl[4]  = '{1, 9'h03C, 8, 0, 1'b0, 1, 2'b11, 9'h03C, 1'b0, 1'b0};
    tbl[5]  = '{2, 9'h041, 8, 1, 1'b1, 1, 2'b11, 9'h041, 1'b1, 1'b0};
    tbl[6]  = '{2, 9'h041, 8, 1, 1'b0, 1, 2'b11, 9'h041, 1'b0, 1'b0};
    tbl[7]  = '{2, 9'h007, 8, 1, 1'b1, 1, 2'b11, 9'h007, 1'b0, 1'b0};
    tbl[8]  = '{2, 9'h007, 8, 1, 1'b0, 1, 2'b11, 9'h007, 1'b1, 1'b0};
    tbl[9]  = '{2, 9'h0FF, 8, 1, 1'b0, 1, 2'b11, 9'h0FF, 1'b0, 1'b0};
    tbl[10] = '{3, 9'h05A, 7, 0, 1'b0, 2, 2'b11, 9'h05A, 1'b0, 1'b0};
    tbl[11] = '{3, 9'h021, 7, 0, 1'b0, 2, 2'b01, 9'h021, 1'b0, 1'b1};

    reset = 1'b1;
    rx = 1'b1;
    data_ready = 1'b1;
    idle(5);
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk_reset_outputs(i, $sformatf("por%0d", i));
    @(posedge clk);
    #1 reset = 1'b0;
    idle(100);

    // Back-to-back frames at the default rate, 3-bit idle gap.
    n0 = nval[0];
    send_frame(9'h041, 8, 0, 1'b0, 1, 2'b11, DEF_BIT);
    @(negedge clk);
    chk_word(0, n0, 9'h041, 1'b0, 1'b0, "b2b_first");
    idle(2 * DEF_BIT);
    send_frame(9'h042, 8, 0, 1'b0, 1, 2'b11, DEF_BIT);
    @(negedge clk);
    chk_word(0, n0 + 1, 9'h042, 1'b0, 1'b0, "b2b_second");
    chk("b2b_ovr", ov_v[0], 0);

    // Glitch of 200 ns on the line.
    n0 = nval[0];
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_rcv_start", rcv_v[0], 1);
    repeat (10) @(posedge clk);
    #1 rx = 1'b1;
    repeat (580) @(negedge clk);
    chk("glitch_rcv_drop", rcv_v[0], 0);
    idle(500);
    chk("glitch_no_word", nval[0] - n0, 0);
    send_frame(9'h055, 8, 0, 1'b0, 1, 2'b11, DEF_BIT);
    @(negedge clk);
    chk_word(0, n0, 9'h055, 1'b0, 1'b0, "glitch_next");

    // Clean restart before the fast-rate tests.
    @(posedge clk);
    #1 reset = 1'b1;
    idle(3);
    #1 reset = 1'b0;
    idle(2 * FAST_BIT);

    for (int i = 0; i < NV; i++) begin
      s = tbl[i].sel;
      n0 = nval[s];
      send_frame(tbl[i].word, tbl[i].nb, tbl[i].par_en, tbl[i].pb, tbl[i].ns,
                 tbl[i].sv, FAST_BIT);
      @(negedge clk);
      chk_word(s, n0, tbl[i].exp_data, tbl[i].exp_perr, tbl[i].exp_ferr,
               $sformatf("vec%0d", i));
      idle(2 * FAST_BIT);
    end

    // Break: rx low for 20 bit times yields one framed zero word.
    n0 = nval[1];
    @(posedge clk);
    #1 rx = 1'b0;
    idle(20 * FAST_BIT);
    @(negedge clk);
    chk_word(1, n0, 9'h000, 1'b0, 1'b1, "break");
    chk("break_rcv", rcv_v[1], 0);
    @(posedge clk);
    #1 rx = 1'b1;
    idle(2 * FAST_BIT);
    chk("break_single", nval[1] - n0, 1);
    send_frame(9'h03C, 8, 0, 1'b0, 1, 2'b11, FAST_BIT);
    @(negedge clk);
    chk_word(1, n0 + 1, 9'h03C, 1'b0, 1'b0, "break_after");
    idle(2 * FAST_BIT);

    // Overrun: consumer stalls across two frames.
    n0 = nval[1];
    @(posedge clk);
    #1 data_ready = 1'b0;
    send_frame(9'h041, 8, 0, 1'b0, 1, 2'b11, FAST_BIT);
    send_frame(9'h042, 8, 0, 1'b0, 1, 2'b11, FAST_BIT);
    @(negedge clk);
    chk("ovr_count", nval[1] - n0, 1);
    chk("ovr_valid", dv_v[1], 1);
    chk("ovr_data", data_v[1], 9'h041);
    chk("ovr_flag", ov_v[1], 1);
    chk("ovr_perr", pe_v[1], 0);
    chk("ovr_ferr", fe_v[1], 0);
    @(posedge clk);
    #1 data_ready = 1'b1;
    @(posedge clk);
    #1 data_ready = 1'b0;
    @(negedge clk);
    chk("ovr_clr_valid", dv_v[1], 0);
    chk("ovr_clr_flag", ov_v[1], 0);
    chk("ovr_clr_ferr", fe_v[1], 0);
    @(posedge clk);
    #1 data_ready = 1'b1;
    idle(2 * FAST_BIT);

    // Reset after 4 data bits, then a full 0x3C frame (8N1, then 7N2).
    for (int k = 0; k < 2; k++) begin
      s = (k == 0) ? 1 : 3;
      n0 = nval[s];
      drive_bit(1'b0, FAST_BIT);
      drive_bit(1'b0, FAST_BIT);
      drive_bit(1'b0, FAST_BIT);
      drive_bit(1'b1, FAST_BIT);
      drive_bit(1'b1, FAST_BIT);
      @(posedge clk);
      #1 begin
        reset = 1'b1;
        rx = 1'b1;
      end
      idle(3);
      @(negedge clk);
      chk_reset_outputs(s, $sformatf("midrst%0d", k));
      @(posedge clk);
      #1 reset = 1'b0;
      idle(3 * FAST_BIT);
      chk($sformatf("midrst%0d_no_word", k), nval[s] - n0, 0);
      send_frame(9'h03C, (k == 0) ? 8 : 7, 0, 1'b0, (k == 0) ? 1 : 2, 2'b11, FAST_BIT);
      @(negedge clk);
      chk_word(s, n0, 9'h03C, 1'b0, 1'b0, $sformatf("midrst%0d_next", k));
      idle(2 * FAST_BIT);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_receiver_cfg.md
# uart_receiver_cfg

Parametrised UART receiver, successor to the fixed 8N1 receiver. It samples the asynchronous `rx` line with a configurable oversampling tick and accepts 5–9 data bits, optional odd/even parity and 1 or 2 stop bits. Each received word is held in an output register with a valid/ready handshake, together with parity, framing and overrun error flags. It sits between the board RX pin and the downstream byte consumer (FIFO or command parser).

## Interface
- `CLK_FREQ`, 100_000_000: clock frequency in Hz.
- `BAUD`, 115200: line rate in bits/s.
- `OVERSAMPLE`, 16: ticks per bit; must be even and ≥ 8.
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `DIV` (localparam) = round(CLK_FREQ / (BAUD·OVERSAMPLE)); 54 at the defaults.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `rx` in 1: serial line; idles high; LSB first.
- `data` out DATA_BITS: received word.
- `data_valid` out 1: word and flags available.
- `data_ready` in 1: consumer accepts the word.
- `parity_err` out 1: parity mismatch on the held word.
- `framing_err` out 1: a stop bit sampled low on the held word.
- `overrun_err` out 1: one or more frames were lost while a word was held.
- `receiving` out 1: high from start-edge detect until the frame completes or is aborted.
- `baud_tick` out 1: single-cycle oversample tick, exposed for debug.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1. All logic below uses the synchronized value `rxs`.
- Tick counter counts 0..DIV-1; `baud_tick` fires when the count reaches DIV-1. The counter is cleared on start detect so sampling is phase-aligned to the frame.
- States:
  - IDLE → START on a falling edge of `rxs`, only if armed. Arming requires `rxs` to be seen high at least once after the previous frame.
  - START: at tick OVERSAMPLE/2, take a majority sample. If it is low, go to DATA. If it is high, treat it as a false start and return to IDLE with `receiving` dropped.
  - DATA: DATA_BITS bits, shifted LSB first.
  - PARITY: only when PARITY≠0.
  - STOP: STOP_BITS bits.
  - After STOP, return to IDLE.
- Every bit value is the majority vote of the samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit counter advances every OVERSAMPLE ticks.
- Parity check: odd parity expects XOR(data, p) = 1; even parity expects 0.
- Frame completion happens at the midpoint of the last stop bit; the FSM returns to IDLE there, so back-to-back frames are accepted.
- On completion:
  - If `data_valid` is 0 or `data_ready` is 1 in that cycle, load `data`, `parity_err` and `framing_err`, and set `data_valid` on the next cycle.
  - Otherwise discard the new frame, keep the held word, and set `overrun_err`.
- Handshake: `data_valid` stays high until the cycle where `data_valid && data_ready`. In that cycle `data_valid` and all three error flags clear, unless a new frame completes in the same cycle. A completion loads the new word and wins.
- Framing error or break (rx low through the stop bit): the word is still delivered with `framing_err`=1. The FSM stays unarmed until `rxs` returns high.
- Reset values:
  - `data`=0, `data_valid`=0, all error flags 0, `receiving`=0, `baud_tick`=0.
  - FSM in IDLE and armed; synchronizer at 1.
- Reset mid-frame aborts the frame with no partial word delivered.

## Timing
- Bit period = DIV·OVERSAMPLE clocks; 864 clocks (8.64 µs) at the defaults.
- Start detect occurs 2 clocks after the `rx` edge (synchronizer), plus 1 edge-detect cycle.
- `data_valid` rises 1 clock after the completion sample. That sample falls about (1 + DATA_BITS + P + STOP_BITS − 0.5) bit periods after the start edge, where P is 1 when parity is enabled and 0 otherwise.
- `receiving` falls in the same cycle `data_valid` is loaded, or on abort.
- Tolerated baud mismatch: ±3% at OVERSAMPLE=16.

## Test plan
- **Back-to-back frames.** Defaults, `data_ready`=1. Send 0x41, then 0x42 after a 3-bit idle gap, bit time 8640 ns. Required: two `data_valid` pulses, `data`=0x41 then 0x42, all error flags 0.
- **Glitch rejection.** Drive `rx` low for 200 ns, then high. Required: `receiving` falls by mid-start, no `data_valid`. A following 0x55 frame is received correctly.
- **Parity error.** PARITY=2. Send 0x41 with parity bit 1. Required: `data`=0x41, `parity_err`=1. Resend with parity bit 0: required `parity_err`=0.
- **Framing error and break.** Send 0xA5 with a stop bit of 0: required `framing_err`=1, `data`=0xA5. Then hold `rx` low for 20 bit times: required exactly one `data_valid` (0x00, `framing_err`=1) and no re-trigger until `rx` returns high.
- **Overrun.** `data_ready`=0, send 0x41 then 0x42. Required: `data` stays 0x41 and `overrun_err`=1. Then pulse `data_ready`: required `data_valid`, `overrun_err` and the other flags clear on the next cycle.
- **Reset mid-frame.** Assert `reset` after 4 data bits of a frame. Required: all outputs at their reset values and no partial word. A subsequent full 0x3C frame is received; repeat with DATA_BITS=7, STOP_BITS=2.
